// File: rtl/id_char_feeder.sv
// rtl/id_char_feeder.sv - buffers a 10-character ASCII ID, validates and converts it,
// then bursts the 6-bit codes to the ID checker followed by a result-window gap.
module id_char_feeder #(
   parameter int ID_LEN     = 10,
   parameter int GAP_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       char_valid,
   input  logic [7:0] char_data,
   input  logic       char_last,
   output logic       char_ready,
   output logic       out_valid,
   output logic [5:0] out_id,
   output logic       fmt_err,
   output logic [1:0] err_code,
   output logic       busy
);

   typedef enum logic [1:0] {S_COLLECT, S_SKIP, S_EMIT, S_GAP} state_t;

   localparam logic [3:0] LAST_POS = 4'(ID_LEN - 1);
   localparam logic [3:0] LAST_GAP = 4'(GAP_CYCLES - 1);

   state_t     r_state;
   logic [3:0] r_pos;
   logic       r_bad;
   logic [3:0] r_idx;
   logic [3:0] r_gap;
   logic       r_fmt_err;
   logic [1:0] r_err_code;
   logic [5:0] r_buf [ID_LEN];

   state_t     w_state_nx;
   logic [3:0] w_pos_nx;
   logic       w_bad_nx;
   logic [3:0] w_idx_nx;
   logic [3:0] w_gap_nx;
   logic       w_fmt_nx;
   logic [1:0] w_code_nx;
   logic       w_wr;
   logic       w_bad_all;
   logic       w_accept;
   logic       w_is_up;
   logic       w_is_lo;
   logic       w_is_dig;
   logic [7:0] w_up;
   logic [5:0] w_let;
   logic [5:0] w_code;
   logic       w_viol;

   assign char_ready = (r_state == S_COLLECT) || (r_state == S_SKIP);
   assign w_accept   = char_valid && char_ready;
   assign out_valid  = (r_state == S_EMIT);
   assign out_id     = out_valid ? r_buf[r_idx] : 6'd0;
   assign busy       = (r_state == S_EMIT) || (r_state == S_GAP);
   assign fmt_err    = r_fmt_err;
   assign err_code   = r_err_code;

   assign w_is_up  = (char_data >= 8'h41) && (char_data <= 8'h5A);
   assign w_is_lo  = (char_data >= 8'h61) && (char_data <= 8'h7A);
   assign w_is_dig = (char_data >= 8'h30) && (char_data <= 8'h39);
   assign w_up     = char_data & 8'hDF;

   // The checker's letter codes skip the ambiguous I/O/W/Z slots, so a table is needed.
   always_comb begin
      w_let = 6'd0;
      case (w_up)
         8'h41: w_let = 6'd10;  8'h42: w_let = 6'd11;  8'h43: w_let = 6'd12;
         8'h44: w_let = 6'd13;  8'h45: w_let = 6'd14;  8'h46: w_let = 6'd15;
         8'h47: w_let = 6'd16;  8'h48: w_let = 6'd17;  8'h49: w_let = 6'd34;
         8'h4A: w_let = 6'd18;  8'h4B: w_let = 6'd19;  8'h4C: w_let = 6'd20;
         8'h4D: w_let = 6'd21;  8'h4E: w_let = 6'd22;  8'h4F: w_let = 6'd35;
         8'h50: w_let = 6'd23;  8'h51: w_let = 6'd24;  8'h52: w_let = 6'd25;
         8'h53: w_let = 6'd26;  8'h54: w_let = 6'd27;  8'h55: w_let = 6'd28;
         8'h56: w_let = 6'd29;  8'h57: w_let = 6'd32;  8'h58: w_let = 6'd30;
         8'h59: w_let = 6'd31;  8'h5A: w_let = 6'd33;
         default: w_let = 6'd0;
      endcase
   end

   always_comb begin
      w_code = 6'd0;
      w_viol = 1'b0;
      if (r_pos == 4'd0) begin
         if (w_is_up || w_is_lo) w_code = w_let;
         else                    w_viol = 1'b1;
      end else if (r_pos == 4'd1) begin
         if (char_data == 8'h31 || char_data == 8'h32) w_code = {2'b00, char_data[3:0]};
         else                                          w_viol = 1'b1;
      end else begin
         if (w_is_dig) w_code = {2'b00, char_data[3:0]};
         else          w_viol = 1'b1;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_pos_nx   = r_pos;
      w_bad_nx   = r_bad;
      w_idx_nx   = r_idx;
      w_gap_nx   = r_gap;
      w_fmt_nx   = 1'b0;
      w_code_nx  = 2'd0;
      w_wr       = 1'b0;
      // Position 0 starts a fresh ID, so the stale flag from a dropped ID is ignored.
      w_bad_all  = ((r_pos == 4'd0) ? 1'b0 : r_bad) | w_viol;
      case (r_state)
         S_COLLECT: begin
            if (w_accept) begin
               w_wr     = 1'b1;
               w_bad_nx = w_bad_all;
               if (r_pos == LAST_POS) begin
                  w_pos_nx = 4'd0;
                  if (!char_last) begin
                     w_fmt_nx   = 1'b1;
                     w_code_nx  = 2'd2;
                     w_state_nx = S_SKIP;
                  end else if (w_bad_all) begin
                     w_fmt_nx  = 1'b1;
                     w_code_nx = 2'd1;
                  end else begin
                     w_idx_nx   = 4'd0;
                     w_state_nx = S_EMIT;
                  end
               end else if (char_last) begin
                  w_pos_nx  = 4'd0;
                  w_fmt_nx  = 1'b1;
                  w_code_nx = 2'd2;
               end else begin
                  w_pos_nx = r_pos + 4'd1;
               end
            end
         end
         S_SKIP: begin
            if (w_accept && char_last) w_state_nx = S_COLLECT;
         end
         S_EMIT: begin
            if (r_idx == LAST_POS) begin
               w_gap_nx   = 4'd0;
               w_state_nx = S_GAP;
            end else begin
               w_idx_nx = r_idx + 4'd1;
            end
         end
         S_GAP: begin
            if (r_gap == LAST_GAP) w_state_nx = S_COLLECT;
            else                   w_gap_nx   = r_gap + 4'd1;
         end
         default: w_state_nx = S_COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_COLLECT;
         r_pos      <= 4'd0;
         r_bad      <= 1'b0;
         r_idx      <= 4'd0;
         r_gap      <= 4'd0;
         r_fmt_err  <= 1'b0;
         r_err_code <= 2'd0;
      end else begin
         r_state    <= w_state_nx;
         r_pos      <= w_pos_nx;
         r_bad      <= w_bad_nx;
         r_idx      <= w_idx_nx;
         r_gap      <= w_gap_nx;
         r_fmt_err  <= w_fmt_nx;
         r_err_code <= w_code_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_buf[r_pos] <= w_code;
   end

endmodule

// File: tb/tb_id_char_feeder.sv
// tb/tb_id_char_feeder.sv - directed bench for id_char_feeder with a string-level
// reference model and a per-cycle output comparator.
module tb_id_char_feeder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       char_valid = 1'b0;
   logic [7:0] char_data = 8'd0;
   logic       char_last = 1'b0;
   logic       char_ready;
   logic       out_valid;
   logic [5:0] out_id;
   logic       fmt_err;
   logic [1:0] err_code;
   logic       busy;

   id_char_feeder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .char_valid (char_valid),
      .char_data  (char_data),
      .char_last  (char_last),
      .char_ready (char_ready),
      .out_valid  (out_valid),
      .out_id     (out_id),
      .fmt_err    (fmt_err),
      .err_code   (err_code),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int exp_q[$];
   int err_q[$];
   int run = 0;
   int cyc = 0;
   int last_rise = 0;
   int prev_rise = 0;
   int lmap[26] = '{10, 11, 12, 13, 14, 15, 16, 17, 34, 18, 19, 20, 21,
                    22, 35, 23, 24, 25, 26, 27, 28, 29, 32, 30, 31, 33};

   task automatic check(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Whole-string view: wrong length -> code 2, bad format -> code 1, else 10 codes.
   task automatic model(input string s);
      int codes[10];
      bit bad;
      int c;
      bad = 0;
      if (s.len() != 10) begin
         err_q.push_back(2);
         return;
      end
      for (int i = 0; i < 10; i++) begin
         c = int'(s[i]);
         codes[i] = 0;
         if (i == 0) begin
            if (c >= 65 && c <= 90)       codes[i] = lmap[c - 65];
            else if (c >= 97 && c <= 122) codes[i] = lmap[c - 97];
            else                          bad = 1;
         end else if (i == 1) begin
            if (c == 49 || c == 50) codes[i] = c - 48;
            else                    bad = 1;
         end else begin
            if (c >= 48 && c <= 57) codes[i] = c - 48;
            else                    bad = 1;
         end
      end
      if (bad) err_q.push_back(1);
      else for (int i = 0; i < 10; i++) exp_q.push_back(codes[i]);
   endtask

   task automatic send_id(input string s);
      bit acc;
      int w;
      model(s);
      for (int i = 0; i < s.len(); i++) begin
         char_valid = 1'b1;
         char_data  = s[i];
         char_last  = (i == s.len() - 1);
         acc = 0;
         w = 0;
         while (!acc && w < 100) begin
            @(negedge clk);
            acc = char_ready;
            @(posedge clk);
            #1;
            w++;
         end
         if (!acc) check("accept_timeout", 0, 1);
      end
      char_valid = 1'b0;
      char_last  = 1'b0;
      char_data  = 8'd0;
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         err_q.delete();
         run = 0;
      end else begin
         cyc++;
         if (out_valid) begin
            if (run == 0) begin
               prev_rise = last_rise;
               last_rise = cyc;
            end
            run++;
            check("busy_in_emit", int'(busy), 1);
            if (exp_q.size() == 0) check("unexpected_out_valid", 1, 0);
            else                   check("out_id", int'(out_id), exp_q.pop_front());
         end else begin
            check("idle_out_id", int'(out_id), 0);
            if (run != 0) begin
               check("burst_len", run, 10);
               run = 0;
            end
         end
         if (fmt_err) begin
            if (err_q.size() == 0) check("unexpected_fmt_err", 1, 0);
            else                   check("err_code", int'(err_code), err_q.pop_front());
         end else begin
            check("idle_err_code", int'(err_code), 0);
         end
      end
   end

   int lit_id1[10] = '{10, 1, 2, 3, 4, 5, 6, 7, 8, 9};

   initial begin
      #2;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_fmt_err", int'(fmt_err), 0);
      check("rst_out_id", int'(out_id), 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("ready_after_release", int'(char_ready), 1);
      @(posedge clk);
      #1;

      // 1: first valid ID, exact burst timing and ready window
      send_id("A123456789");
      for (int k = 0; k < 13; k++) begin
         if (k < 10) begin
            check("t1_valid", int'(out_valid), 1);
            check("t1_id_lit", int'(out_id), lit_id1[k]);
         end
         check("t1_ready", int'(char_ready), (k < 12) ? 0 : 1);
         check("t1_busy", int'(busy), (k < 12) ? 1 : 0);
         @(posedge clk);
         #1;
      end

      // 2: lowercase, remapped letter
      send_id("i234567890");
      check("t2_first_lit", int'(out_id), 34);
      repeat (14) @(posedge clk);
      #1;

      // 3: bad characters, then a good ID
      send_id("A3xx567890");
      check("t3_err_lit", int'(fmt_err), 1);
      check("t3_code_lit", int'(err_code), 1);
      check("t3_no_valid", int'(out_valid), 0);
      send_id("1234567890");
      check("t3b_code_lit", int'(err_code), 1);
      send_id("Z212345678");
      repeat (14) @(posedge clk);
      #1;

      // 4: early end, then too long with swallowed tail
      send_id("A1234");
      check("t4_err_lit", int'(fmt_err), 1);
      check("t4_code_lit", int'(err_code), 2);
      check("t4_ready", int'(char_ready), 1);
      send_id("A12345678901");
      check("t4b_no_valid", int'(out_valid), 0);
      check("t4b_ready", int'(char_ready), 1);
      repeat (3) @(posedge clk);
      #1;

      // 5: back-to-back IDs with char_valid held
      send_id("B198765432");
      send_id("c200000000");
      repeat (14) @(posedge clk);
      #1;
      check("t5_rise_spacing", last_rise - prev_rise, 22);

      // 6: reset in the 4th burst cycle
      send_id("D111111111");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("t6_async_valid", int'(out_valid), 0);
      check("t6_async_busy", int'(busy), 0);
      check("t6_async_id", int'(out_id), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("t6_ready", int'(char_ready), 1);
      @(posedge clk);
      #1;
      send_id("E222222222");
      check("t6_valid", int'(out_valid), 1);
      check("t6_first_lit", int'(out_id), 14);
      repeat (14) @(posedge clk);
      #1;

      check("exp_q_drained", exp_q.size(), 0);
      check("err_q_drained", err_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

endmodule

// File: doc/id_char_feeder.md
Name: id_char_feeder

Overview:
- Upstream front end for the ID checker.
- Accepts an ASCII ID string one character per handshake and buffers all 10 characters.
- Validates format and converts each character to the checker's 6-bit code: letter to 10..35, digit to 0..9.
- Drives the checker's in_valid/in_id as an unbroken 10-cycle burst, then holds off for the checker's result window before accepting the next ID.

Parameters:
ID_LEN, 10, characters per ID; the checker requires 10.
GAP_CYCLES, 2, idle cycles after a burst before new characters are accepted; covers the checker's result and clear cycles.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
char_valid  in  1  upstream character valid
char_data  in  8  ASCII character
char_last  in  1  marks final character of an ID; qualified by char_valid
char_ready  out  1  feeder accepts a character this cycle
out_valid  out  1  to checker in_valid
out_id  out  6  to checker in_id
fmt_err  out  1  one-cycle pulse: ID dropped, not sent to checker
err_code  out  2  valid with fmt_err: 1 = bad character, 2 = length error
busy  out  1  high in EMIT and GAP

Behaviour:
- Reset (async, rst_n low):
  - out_valid, out_id, fmt_err, err_code, busy = 0.
  - State = COLLECT, position = 0, bad flag cleared, buffer contents don't-care.
- Reset mid-burst: out_valid drops immediately and the partial ID is discarded; no resume.
- Handshake: a character is accepted when char_valid && char_ready. char_ready is combinational: 1 in COLLECT and SKIP, else 0. It is 1 in the first cycle after reset release.
- Conversion, registered into a 10x6 buffer at the current position:
  - Position 0 must be a letter, A-Z or a-z (case-insensitive).
  - Letter map: A10 B11 C12 D13 E14 F15 G16 H17 I34 J18 K19 L20 M21 N22 O35 P23 Q24 R25 S26 T27 U28 V29 W32 X30 Y31 Z33.
  - Position 1 must be '1' or '2'.
  - Positions 2..9 must be '0'..'9'; digit code = char - 0x30.
  - Any violation sets the bad flag and stores 0; collection continues.
- COLLECT:
  - On accept at position p < 9 with char_last = 1 (early end): drop the ID. fmt_err = 1 with code 2 next cycle; position = 0; stay in COLLECT.
  - On accept at p = 9 with char_last = 1:
    - If bad flag set: fmt_err with code 1 next cycle; position = 0; stay in COLLECT.
    - Else go to EMIT.
  - On accept at p = 9 with char_last = 0 (too long): fmt_err with code 2 next cycle; go to SKIP.
  - Code 2 takes priority over code 1 whenever both apply.
- SKIP: accept and discard characters until one with char_last = 1 is accepted (inclusive), then COLLECT with position 0. No further fmt_err in SKIP.
- EMIT:
  - If the 10th character is accepted at cycle T, out_valid = 1 for cycles T+1..T+10.
  - out_id = buffer[0..9] in order, one entry per cycle, with no gaps.
  - out_id = 0 whenever out_valid = 0.
- GAP: cycles T+11..T+10+GAP_CYCLES. out_valid = 0 and char_ready = 0.
- Return: COLLECT from T+11+GAP_CYCLES, with char_ready = 1 from that cycle.
- busy = 1 exactly in EMIT and GAP.
- fmt_err is a registered single-cycle pulse; err_code returns to 0 with it.
- Position counter: 4 bits, wraps 9 -> 0 only via the transitions above.

Test Plan:
1. Reset release, then feed "A123456789" back-to-back, last on '9' -> out_valid high 10 consecutive cycles starting the cycle after '9'. out_id = 10,1,2,3,4,5,6,7,8,9. char_ready low for 12 cycles, then high.
2. Feed "i234567890" (lowercase, remapped letter) -> out_id first value 34, then 2,3,4,5,6,7,8,9,0. Verify against a checker model.
3. Feed "A3xx..." (bad position-1 digit) and "1234567890" (digit first) -> no out_valid; fmt_err pulse with err_code = 1 after the 10th character; next valid ID is emitted normally.
4. char_last on the 5th character -> fmt_err with err_code = 2 the next cycle, char_ready stays high. Then 12 characters with last on the 12th -> fmt_err code 2 after the 10th character, characters 11-12 swallowed, no emission.
5. Two valid IDs with char_valid held high continuously -> exactly two 10-cycle bursts separated by GAP_CYCLES = 2 idle cycles plus the next 10 accepts; no character lost.
6. Assert rst_n low at the 4th cycle of a burst -> out_valid and busy fall asynchronously. After release, char_ready = 1, position 0; a new ID emits correctly.
